// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared types and constants for the nibble-serial SRAM BIST bus master.
// Provides the bus width defines (when not already defined elsewhere), the BIST opcodes,
// the master FSM state enum, per-phase nibble/cycle counts and a terminal-count helper.

`ifndef BIST_OP_WIDTH
`define BIST_OP_WIDTH 3
`endif
`ifndef SRAM_WRAPPER_BUS_WIDTH
`define SRAM_WRAPPER_BUS_WIDTH 4
`endif
`ifndef JTAG_DATA_REQ_WIDTH
`define JTAG_DATA_REQ_WIDTH 192
`endif
`ifndef JTAG_DATA_RES_WIDTH
`define JTAG_DATA_RES_WIDTH 256
`endif

package sram_bist_pkg;

    localparam int unsigned OP_W = `BIST_OP_WIDTH;

    // Bus opcodes; all-zero is the idle code every slave treats as "return to IDLE".
    localparam logic [OP_W-1:0] IDLE_CMD              = {`BIST_OP_WIDTH{1'b0}};
    localparam logic [OP_W-1:0] BIST_OP_SHIFT_ID      = OP_W'(1);
    localparam logic [OP_W-1:0] BIST_OP_SHIFT_BSEL    = OP_W'(2);
    localparam logic [OP_W-1:0] BIST_OP_SHIFT_ADDRESS = OP_W'(3);
    localparam logic [OP_W-1:0] BIST_OP_READ          = OP_W'(4);
    localparam logic [OP_W-1:0] BIST_OP_SHIFT_DATA    = OP_W'(5);

    localparam int unsigned ID_NIB   = 2;
    localparam int unsigned BSEL_NIB = 2;
    localparam int unsigned ADDR_NIB = 4;
    localparam int unsigned WR_NIB   = 48;
    localparam int unsigned RD_NIB   = 64;
    localparam int unsigned GAP_CYC  = 2;

    typedef enum logic [3:0] {
        StIdle,
        StShId,
        StShBsel,
        StShAddr,
        StRdCmd,
        StRdWait,
        StRdShift,
        StWrShift,
        StGap,
        StResp
    } state_e;

    // Value of the 6-bit phase counter on the last cycle of an n-cycle phase.
    function automatic logic [5:0] last_cnt(input int unsigned n);
        return 6'(n - 1);
    endfunction

endpackage

// File: rtl/bist_nibble_shifter.sv
// bist_nibble_shifter: 192-bit loadable MSB-first shift-out register (write data) paired
// with a 256-bit shift-in register (read data, first nibble ends up in [255:252]).
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_load, i_load_data load the shift-out register (priority over i_shift_out)
//   i_shift_out         advance the shift-out register by one nibble
//   o_nib               current top nibble of the shift-out register
//   i_shift_in, i_nib   shift a nibble into the bottom of the shift-in register
//   o_word              shift-in register contents

module bist_nibble_shifter
    import sram_bist_pkg::*;
(
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_load,
    input  logic [`JTAG_DATA_REQ_WIDTH-1:0]        i_load_data,
    input  logic                                   i_shift_out,
    output logic [`SRAM_WRAPPER_BUS_WIDTH-1:0]     o_nib,
    input  logic                                   i_shift_in,
    input  logic [`SRAM_WRAPPER_BUS_WIDTH-1:0]     i_nib,
    output logic [`JTAG_DATA_RES_WIDTH-1:0]        o_word
);

    localparam int unsigned NW = `SRAM_WRAPPER_BUS_WIDTH;
    localparam int unsigned OW = `JTAG_DATA_REQ_WIDTH;
    localparam int unsigned IW = `JTAG_DATA_RES_WIDTH;

    logic [OW-1:0] r_out;
    logic [IW-1:0] r_in;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out <= '0;
            r_in  <= '0;
        end else begin
            if (i_load) begin
                r_out <= i_load_data;
            end else if (i_shift_out) begin
                r_out <= {r_out[OW-NW-1:0], {NW{1'b0}}};
            end
            if (i_shift_in) begin
                r_in <= {r_in[IW-NW-1:0], i_nib};
            end
        end
    end

    assign o_nib  = r_out[OW-1 -: NW];
    assign o_word = r_in;

endmodule

// File: rtl/sram_bist_master.sv
// sram_bist_master: turns one parallel read/write request into the command/data nibble
// sequence of the SRAM BIST debug bus and returns read data as a 256-bit word.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_wr, req_sram_id, req_bsel,    request fields, latched on acceptance
//   req_addr, req_wdata
//   rsp_valid/rsp_ready               response handshake (rsp_valid held until accepted)
//   rsp_wr, rsp_rdata                 response: write echo, read data (nibble 0 in [255:252])
//   bist_command, bist_data           broadcast bus outputs (registered)
//   bist_rdata                        read-back nibble from the SRAM wrappers

module sram_bist_master
    import sram_bist_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_wr,
    input  logic [7:0]                             req_sram_id,
    input  logic [7:0]                             req_bsel,
    input  logic [15:0]                            req_addr,
    input  logic [`JTAG_DATA_REQ_WIDTH-1:0]        req_wdata,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic                                   rsp_wr,
    output logic [`JTAG_DATA_RES_WIDTH-1:0]        rsp_rdata,
    output logic [`BIST_OP_WIDTH-1:0]              bist_command,
    output logic [`SRAM_WRAPPER_BUS_WIDTH-1:0]     bist_data,
    input  logic [`SRAM_WRAPPER_BUS_WIDTH-1:0]     bist_rdata
);

    state_e      r_state;
    logic [5:0]  r_cnt;
    logic        r_wr;
    // Header nibbles still to send: id[3:0], bsel, addr (id[7:4] goes out on acceptance).
    logic [31:0] r_hdr;

    logic                                w_accept;
    logic                                w_shift_out;
    logic                                w_shift_in;
    logic [`SRAM_WRAPPER_BUS_WIDTH-1:0]  w_out_nib;

    assign w_accept    = (r_state == StIdle) && req_valid && req_ready;
    // Pop a write nibble on every edge that launches one onto the bus.
    assign w_shift_out = ((r_state == StShAddr) && (r_cnt == last_cnt(ADDR_NIB)) && r_wr) ||
                         ((r_state == StWrShift) && (r_cnt != last_cnt(WR_NIB)));
    assign w_shift_in  = (r_state == StRdShift);

    bist_nibble_shifter u_shifter (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load      (w_accept),
        .i_load_data (req_wdata),
        .i_shift_out (w_shift_out),
        .o_nib       (w_out_nib),
        .i_shift_in  (w_shift_in),
        .i_nib       (bist_rdata),
        .o_word      (rsp_rdata)
    );

    // Each branch sets the bus value for the following cycle, so outputs stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_wr         <= 1'b0;
            r_hdr        <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_wr       <= 1'b0;
            bist_command <= IDLE_CMD;
            bist_data    <= '0;
        end else begin
            r_cnt        <= r_cnt + 6'd1;
            bist_command <= IDLE_CMD;
            bist_data    <= '0;
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_state      <= StShId;
                        r_wr         <= req_wr;
                        r_hdr        <= {req_sram_id[3:0], req_bsel, req_addr, 4'h0};
                        req_ready    <= 1'b0;
                        bist_command <= BIST_OP_SHIFT_ID;
                        bist_data    <= req_sram_id[7:4];
                    end
                end
                StShId: begin
                    bist_command <= BIST_OP_SHIFT_ID;
                    bist_data    <= r_hdr[31:28];
                    r_hdr        <= {r_hdr[27:0], 4'h0};
                    if (r_cnt == last_cnt(ID_NIB)) begin
                        r_state      <= StShBsel;
                        r_cnt        <= '0;
                        bist_command <= BIST_OP_SHIFT_BSEL;
                    end
                end
                StShBsel: begin
                    bist_command <= BIST_OP_SHIFT_BSEL;
                    bist_data    <= r_hdr[31:28];
                    r_hdr        <= {r_hdr[27:0], 4'h0};
                    if (r_cnt == last_cnt(BSEL_NIB)) begin
                        r_state      <= StShAddr;
                        r_cnt        <= '0;
                        bist_command <= BIST_OP_SHIFT_ADDRESS;
                    end
                end
                StShAddr: begin
                    if (r_cnt == last_cnt(ADDR_NIB)) begin
                        r_cnt <= '0;
                        if (r_wr) begin
                            r_state      <= StWrShift;
                            bist_command <= BIST_OP_SHIFT_DATA;
                            bist_data    <= w_out_nib;
                        end else begin
                            r_state      <= StRdCmd;
                            bist_command <= BIST_OP_READ;
                        end
                    end else begin
                        bist_command <= BIST_OP_SHIFT_ADDRESS;
                        bist_data    <= r_hdr[31:28];
                        r_hdr        <= {r_hdr[27:0], 4'h0};
                    end
                end
                StRdCmd: begin
                    r_state <= StRdWait;
                    r_cnt   <= '0;
                end
                StRdWait: begin
                    r_state      <= StRdShift;
                    r_cnt        <= '0;
                    bist_command <= BIST_OP_SHIFT_DATA;
                end
                StRdShift: begin
                    if (r_cnt == last_cnt(RD_NIB)) begin
                        r_state   <= StResp;
                        r_cnt     <= '0;
                        rsp_valid <= 1'b1;
                        rsp_wr    <= r_wr;
                    end else begin
                        bist_command <= BIST_OP_SHIFT_DATA;
                    end
                end
                StWrShift: begin
                    if (r_cnt == last_cnt(WR_NIB)) begin
                        r_state <= StGap;
                        r_cnt   <= '0;
                    end else begin
                        bist_command <= BIST_OP_SHIFT_DATA;
                        bist_data    <= w_out_nib;
                    end
                end
                StGap: begin
                    if (r_cnt == last_cnt(GAP_CYC)) begin
                        r_state   <= StResp;
                        r_cnt     <= '0;
                        rsp_valid <= 1'b1;
                        rsp_wr    <= r_wr;
                    end
                end
                StResp: begin
                    r_cnt <= '0;
                    if (rsp_ready) begin
                        r_state   <= StIdle;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bist_master.sv
module tb_sram_bist_master;
    import sram_bist_pkg::*;

    localparam logic [7:0] SLAVE_ID = 8'h25;
    localparam logic [191:0] WD1 = 192'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
    localparam logic [191:0] WD2 = 192'hFEDCBA9876543210_1122334455667788_99AABBCCDDEEFF00;
    localparam logic [191:0] WD3 = 192'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A_0F0F0F0F0F0F0F0F;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid, req_ready, req_wr;
    logic [7:0]          req_sram_id, req_bsel;
    logic [15:0]         req_addr;
    logic [191:0]        req_wdata;
    logic                rsp_valid, rsp_ready, rsp_wr;
    logic [255:0]        rsp_rdata;
    logic [OP_W-1:0]     bist_command;
    logic [3:0]          bist_data, bist_rdata;

    always #5 clk = ~clk;

    sram_bist_master dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_sram_id  (req_sram_id),
        .req_bsel     (req_bsel),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_wr       (rsp_wr),
        .rsp_rdata    (rsp_rdata),
        .bist_command (bist_command),
        .bist_data    (bist_data),
        .bist_rdata   (bist_rdata)
    );

    // Behavioural sp_ram wrapper with ID 0x25 and a 256-entry memory of 256-bit words.
    logic [255:0]    mem [0:255];
    logic [7:0]      s_id, s_bsel;
    logic [15:0]     s_addr;
    logic [255:0]    s_sh;
    logic [191:0]    s_wd;
    logic            s_rd;
    int              s_nwr, s_wcnt;
    logic [OP_W-1:0] s_last_cmd;
    logic            pl_en;
    logic [7:0]      pl_addr;
    logic [255:0]    pl_data;

    assign bist_rdata = (s_rd && s_id == SLAVE_ID) ? s_sh[255:252] : 4'h0;

    always_ff @(posedge clk) begin
        s_last_cmd <= bist_command;
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bist_command == BIST_OP_SHIFT_ID) begin
            s_id  <= {s_id[3:0], bist_data};
            s_rd  <= 1'b0;
            s_nwr <= 0;
        end else if (bist_command == BIST_OP_SHIFT_BSEL) begin
            s_bsel <= {s_bsel[3:0], bist_data};
        end else if (bist_command == BIST_OP_SHIFT_ADDRESS) begin
            s_addr <= {s_addr[11:0], bist_data};
        end else if (bist_command == BIST_OP_READ) begin
            s_sh <= mem[s_addr[7:0]];
            s_rd <= 1'b1;
        end else if (bist_command == BIST_OP_SHIFT_DATA) begin
            if (s_rd) s_sh <= {s_sh[251:0], 4'h0};
            else begin
                s_wd  <= {s_wd[187:0], bist_data};
                s_nwr <= s_nwr + 1;
            end
        end else if (bist_command == IDLE_CMD) begin
            if (!s_rd && s_nwr == 48 && s_id == SLAVE_ID) begin
                mem[s_addr[7:0]] <= {64'h0, s_wd};
                s_wcnt <= s_wcnt + 1;
            end
            s_nwr <= 0;
        end
    end

    typedef struct {
        logic         wr;
        logic [7:0]   id;
        logic [7:0]   bsel;
        logic [15:0]  addr;
        logic [191:0] wd;
        logic [255:0] exp_rd;
    } vec_t;

    typedef struct {
        int              lat;
        logic [8*OP_W-1:0] cmds;
        logic [31:0]     hdr;
        logic [OP_W-1:0] cmd9;
        logic [OP_W-1:0] cmd10;
        int              nshift;
        logic [255:0]    wcap;
        logic [255:0]    rd;
        logic            rwr;
        logic            rr;
    } res_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request and trace the bus until rsp_valid; returns at T+lat (+1 time unit).
    task automatic run_txn(input vec_t v, output res_t r);
        int guard;
        r = '{default: '0};
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("req_ready_before_req", req_ready, 1);
        req_valid   = 1'b1;
        req_wr      = v.wr;
        req_sram_id = v.id;
        req_bsel    = v.bsel;
        req_addr    = v.addr;
        req_wdata   = v.wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = '0;
        for (int k = 1; k <= 200; k++) begin
            if (k <= 8) begin
                r.cmds = {r.cmds[7*OP_W-1:0], bist_command};
                r.hdr  = {r.hdr[27:0], bist_data};
            end
            if (k == 9)  r.cmd9  = bist_command;
            if (k == 10) r.cmd10 = bist_command;
            if (bist_command == BIST_OP_SHIFT_DATA) begin
                r.nshift++;
                r.wcap = {r.wcap[251:0], bist_data};
            end
            if (rsp_valid) begin
                r.lat = k;
                r.rd  = rsp_rdata;
                r.rwr = rsp_wr;
                r.rr  = req_ready;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    vec_t              vecs [8];
    res_t              res;
    vec_t              v;
    logic [8*OP_W-1:0] exp_cmds;
    int                wcnt0;
    int                bad;
    logic [255:0]      held;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 8'h25, 8'h00, 16'h0013, 192'h0, {224'h0, 32'hDEADBEEF}};
        vecs[1] = '{1'b1, 8'h25, 8'h00, 16'h0013, WD1,    {224'h0, 32'hDEADBEEF}};
        vecs[2] = '{1'b0, 8'h25, 8'h00, 16'h0013, 192'h0, {64'h0, WD1}};
        vecs[3] = '{1'b0, 8'h7F, 8'h00, 16'h0013, 192'h0, 256'h0};
        vecs[4] = '{1'b1, 8'h7F, 8'h00, 16'h0013, WD3,    256'h0};
        vecs[5] = '{1'b0, 8'h25, 8'h00, 16'h0013, 192'h0, {64'h0, WD1}};
        vecs[6] = '{1'b1, 8'h25, 8'hA5, 16'h00FE, WD2,    {64'h0, WD1}};
        vecs[7] = '{1'b0, 8'h25, 8'hA5, 16'h00FE, 192'h0, {64'h0, WD2}};
        exp_cmds = {BIST_OP_SHIFT_ID, BIST_OP_SHIFT_ID, BIST_OP_SHIFT_BSEL, BIST_OP_SHIFT_BSEL,
                    BIST_OP_SHIFT_ADDRESS, BIST_OP_SHIFT_ADDRESS, BIST_OP_SHIFT_ADDRESS,
                    BIST_OP_SHIFT_ADDRESS};

        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_sram_id = '0; req_bsel = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        s_id = '0; s_bsel = '0; s_addr = '0; s_sh = '0; s_wd = '0; s_rd = 1'b0;
        s_nwr = 0; s_wcnt = 0;
        pl_en = 1'b1; pl_addr = 8'h13; pl_data = {224'h0, 32'hDEADBEEF};
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_wr", rsp_wr, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_bus", {bist_command, bist_data}, 0);
        @(posedge clk); #1;
        pl_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table: back-to-back transactions with rsp_ready held high.
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            wcnt0 = s_wcnt;
            run_txn(v, res);
            chk($sformatf("v%0d_hdr_cmds", i), res.cmds, exp_cmds);
            chk($sformatf("v%0d_hdr_data", i), res.hdr, {v.id, v.bsel, v.addr});
            chk($sformatf("v%0d_cmd9", i), res.cmd9, v.wr ? BIST_OP_SHIFT_DATA : BIST_OP_READ);
            chk($sformatf("v%0d_cmd10", i), res.cmd10, v.wr ? BIST_OP_SHIFT_DATA : IDLE_CMD);
            chk($sformatf("v%0d_nshift", i), res.nshift, v.wr ? 48 : 64);
            chk($sformatf("v%0d_data_bus", i), res.wcap, v.wr ? {64'h0, v.wd} : 256'h0);
            chk($sformatf("v%0d_latency", i), res.lat, v.wr ? 59 : 75);
            chk($sformatf("v%0d_rsp_wr", i), res.rwr, v.wr);
            chk($sformatf("v%0d_rdata", i), res.rd, v.exp_rd);
            chk($sformatf("v%0d_req_ready_resp", i), res.rr, 0);
            chk($sformatf("v%0d_slave_writes", i), s_wcnt,
                wcnt0 + ((v.wr && v.id == SLAVE_ID) ? 1 : 0));
            if (v.wr && v.id == SLAVE_ID)
                chk($sformatf("v%0d_slave_mem", i), mem[v.addr[7:0]], {64'h0, v.wd});
            @(posedge clk); #1;
            chk($sformatf("v%0d_after_resp", i),
                {req_ready, rsp_valid, bist_command, bist_data}, {1'b1, 1'b0, 7'h0});
        end
        chk("id7f_mem_intact", mem[8'h13], {64'h0, WD1});

        // Response stall: rsp_ready low for 10 cycles.
        rsp_ready = 1'b0;
        v = vecs[2];
        run_txn(v, res);
        chk("stall_latency", res.lat, 75);
        chk("stall_rdata", res.rd, {64'h0, WD1});
        held = rsp_rdata;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata !== held || bist_command != IDLE_CMD ||
                bist_data != 4'h0 || req_ready) bad++;
        end
        chk("stall_stable_cycles", bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", {req_ready, rsp_valid}, 2'b10);

        // Reset at T+30 of a read.
        req_valid = 1'b1; req_wr = 1'b0; req_sram_id = 8'h25; req_bsel = 8'h00;
        req_addr = 16'h0013;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        chk("t30_shift_data", bist_command, BIST_OP_SHIFT_DATA);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {req_ready, rsp_valid, rsp_wr, bist_command, bist_data},
            {3'b100, 7'h0});
        chk("midrst_rdata", rsp_rdata, 0);
        @(posedge clk); #1;
        chk("midrst_slave_idle", s_last_cmd, IDLE_CMD);
        rst = 1'b0;
        @(posedge clk); #1;
        run_txn(vecs[5], res);
        chk("post_rst_latency", res.lat, 75);
        chk("post_rst_rdata", res.rd, {64'h0, WD1});
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
